// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture packet sequencer.
package capture_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPhase,
    StData,
    StRest,
    StDone
  } cap_state_e;

  // Last path index before wrapping, for the 96-path and 48-path layouts.
  localparam logic [6:0] PATH96_MAX = 7'd95;
  localparam logic [6:0] PATH48_MAX = 7'd47;

  // Words per packet for a 2-bit length code.
  function automatic logic [11:0] decode_len(input logic [1:0] code);
    logic [11:0] n;
    case (code)
      2'd0:    n = 12'd256;
      2'd1:    n = 12'd512;
      2'd2:    n = 12'd1024;
      default: n = 12'd2048;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/capture_pkt_ctrl_if.sv
// Capture controls in, packet word stream and status out.
interface capture_pkt_ctrl_if #(
  parameter int unsigned DW = 9,
  parameter int unsigned AW = 15
);
  logic          rf_capture_mode_sync;
  logic          rf_capture_start_sync;
  logic          rf_capture_again_sync;
  logic          rf_96path_en_sync;
  logic [1:0]    rf_pkt_data_length_sync;
  logic [15:0]   rf_pkt_idle_length_sync;
  logic [8:0]    rf_pktctrl_gap_sync;
  logic [8:0]    rf_pktctrl_phase_sync;
  logic [DW-1:0] adc_data;

  logic          pkt_valid;
  logic          pkt_sop;
  logic          pkt_eop;
  logic [DW-1:0] pkt_data;
  logic [6:0]    pkt_path;
  logic [AW-1:0] cap_waddr;
  logic          cap_busy;
  logic          cap_done;

  // Sequencer side: consumes controls and samples, produces the stream.
  modport master (
    input  rf_capture_mode_sync, rf_capture_start_sync, rf_capture_again_sync,
           rf_96path_en_sync, rf_pkt_data_length_sync, rf_pkt_idle_length_sync,
           rf_pktctrl_gap_sync, rf_pktctrl_phase_sync, adc_data,
    output pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_path, cap_waddr, cap_busy, cap_done
  );

  // Register-file / sink side.
  modport slave (
    output rf_capture_mode_sync, rf_capture_start_sync, rf_capture_again_sync,
           rf_96path_en_sync, rf_pkt_data_length_sync, rf_pkt_idle_length_sync,
           rf_pktctrl_gap_sync, rf_pktctrl_phase_sync, adc_data,
    input  pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_path, cap_waddr, cap_busy, cap_done
  );

endinterface

// File: rtl/cap_edge_det.sv
// Synchronous rising-edge detector. The history register resets high so a
// level already asserted when reset is released does not count as an edge.
module cap_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Remember the previous sample.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/capture_pkt_ctrl.sv
// Capture packet sequencer: frames the ADC stream into fixed-length packets
// separated by idle periods and generates capture-memory write addresses.
module capture_pkt_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned DW = 9,
  parameter int unsigned AW = 15
) (
  input logic                pktctrl_clk,
  input logic                pktctrl_rstn,
  capture_pkt_ctrl_if.master bus
);

  logic start;
  logic start_rise;
  logic again_rise;

  cap_state_e    state_q;
  logic [8:0]    phase_cnt_q;
  logic [8:0]    gap_cnt_q;
  logic [11:0]   word_cnt_q;
  logic [15:0]   rest_cnt_q;
  logic [AW-1:0] addr_q;
  logic [6:0]    path_q;

  // Packet configuration captured on every DATA entry.
  logic [11:0]   len_q;
  logic [8:0]    gap_q;
  logic [15:0]   idle_q;
  logic          mode_q;
  logic          p96_q;

  logic          valid_q;
  logic          sop_q;
  logic          eop_q;
  logic [DW-1:0] data_q;
  logic [6:0]    path_out_q;
  logic [AW-1:0] waddr_q;
  logic          busy_q;
  logic          done_q;

  logic          emit;
  logic          last;
  logic          enter_data;
  logic [6:0]    path_max;

  assign start = bus.rf_capture_start_sync;

  cap_edge_det u_start_edge (
    .clk_i  (pktctrl_clk),
    .rst_ni (pktctrl_rstn),
    .d_i    (bus.rf_capture_start_sync),
    .rise_o (start_rise)
  );

  cap_edge_det u_again_edge (
    .clk_i  (pktctrl_clk),
    .rst_ni (pktctrl_rstn),
    .d_i    (bus.rf_capture_again_sync),
    .rise_o (again_rise)
  );

  // Emit / end-of-packet decode and detection of a (re)entry into DATA.
  always_comb begin
    path_max   = p96_q ? PATH96_MAX : PATH48_MAX;
    emit       = (state_q == StData) && (gap_cnt_q == '0);
    last       = emit && (word_cnt_q == len_q - 12'd1);
    enter_data = ((state_q == StPhase) && (phase_cnt_q == '0)) ||
                 ((state_q == StRest) && (rest_cnt_q == '0) && start) ||
                 (last && mode_q && (idle_q == '0) && start);
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge pktctrl_clk) begin
    if (!pktctrl_rstn) begin
      state_q     <= StIdle;
      phase_cnt_q <= '0;
      gap_cnt_q   <= '0;
      word_cnt_q  <= '0;
      rest_cnt_q  <= '0;
      addr_q      <= '0;
      path_q      <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      idle_q      <= '0;
      mode_q      <= 1'b0;
      p96_q       <= 1'b0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
      path_out_q  <= '0;
      waddr_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= (state_q != StIdle) && (state_q != StDone);
      done_q  <= (state_q == StDone);

      case (state_q)
        StIdle: begin
          if (start_rise) begin
            state_q     <= StPhase;
            phase_cnt_q <= bus.rf_pktctrl_phase_sync;
            addr_q      <= '0;
            path_q      <= '0;
          end
        end
        StPhase: begin
          if (phase_cnt_q == '0) begin
            state_q   <= StData;
            gap_cnt_q <= '0;
          end else begin
            phase_cnt_q <= phase_cnt_q - 9'd1;
          end
        end
        StData: begin
          if (emit) begin
            gap_cnt_q  <= gap_q;
            word_cnt_q <= word_cnt_q + 12'd1;
            valid_q    <= 1'b1;
            sop_q      <= (word_cnt_q == '0);
            eop_q      <= last;
            data_q     <= bus.adc_data;
            waddr_q    <= addr_q;
            path_out_q <= path_q;
            addr_q     <= addr_q + AW'(1);
            path_q     <= (path_q == path_max) ? 7'd0 : path_q + 7'd1;
            if (last) begin
              word_cnt_q <= '0;
              if (!mode_q) begin
                state_q <= StDone;
              end else if (idle_q == '0) begin
                // Back-to-back packets: stay in DATA while start is held.
                if (!start) state_q <= StIdle;
              end else begin
                state_q    <= StRest;
                rest_cnt_q <= idle_q - 16'd1;
              end
            end
          end else begin
            gap_cnt_q <= gap_cnt_q - 9'd1;
          end
        end
        StRest: begin
          if (rest_cnt_q == '0) begin
            state_q <= start ? StData : StIdle;
          end else begin
            rest_cnt_q <= rest_cnt_q - 16'd1;
          end
        end
        StDone: begin
          // Re-arm keeps the address running; it takes priority over stop.
          if (again_rise) begin
            state_q     <= StPhase;
            phase_cnt_q <= bus.rf_pktctrl_phase_sync;
          end else if (!start) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // gap_cnt is deliberately not cleared here: between packets it still
      // holds the reloaded gap, which adds gap cycles to the idle spacing.
      if (enter_data) begin
        word_cnt_q <= '0;
        len_q      <= decode_len(bus.rf_pkt_data_length_sync);
        gap_q      <= bus.rf_pktctrl_gap_sync;
        idle_q     <= bus.rf_pkt_idle_length_sync;
        mode_q     <= bus.rf_capture_mode_sync;
        p96_q      <= bus.rf_96path_en_sync;
      end
    end
  end

  assign bus.pkt_valid = valid_q;
  assign bus.pkt_sop   = sop_q;
  assign bus.pkt_eop   = eop_q;
  assign bus.pkt_data  = data_q;
  assign bus.pkt_path  = path_out_q;
  assign bus.cap_waddr = waddr_q;
  assign bus.cap_busy  = busy_q;
  assign bus.cap_done  = done_q;

endmodule

// File: tb/tb_capture_pkt_ctrl.sv
// Bench for capture_pkt_ctrl: random ADC samples, word stream compared against
// a cycle-stamped model built from the packet timing rules.
module tb_capture_pkt_ctrl;

  localparam int DW = 9;
  localparam int AW = 15;

  typedef struct packed {
    int            cyc;
    logic          sop;
    logic          eop;
    logic [6:0]    path;
    logic [AW-1:0] waddr;
    logic [DW-1:0] data;
  } word_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_addr;
  int   m_path;

  logic [DW-1:0] adc_hist [int];
  word_t         obs[$];
  word_t         exp_q[$];

  capture_pkt_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  capture_pkt_ctrl #(.DW(DW), .AW(AW)) dut (
    .pktctrl_clk  (clk),
    .pktctrl_rstn (rstn),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  // Cycle counter and random ADC samples; adc_hist[c] is the sample in cycle c.
  initial begin
    bus.adc_data = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1 bus.adc_data = DW'($urandom);
      adc_hist[cyc] = bus.adc_data;
    end
  end

  // Collect every emitted word with the cycle it appeared in.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.pkt_valid === 1'b1)
        obs.push_back({cyc, bus.pkt_sop, bus.pkt_eop, bus.pkt_path, bus.cap_waddr, bus.pkt_data});
    end
  end

  function automatic string fmt(word_t w);
    return $sformatf("cyc=%0d sop=%b eop=%b path=%0d waddr=%0d data=%h",
                     w.cyc, w.sop, w.eop, w.path, w.waddr, w.data);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cfg(input bit mode, input bit p96, input int len, input int gap,
                         input int idle, input int phase);
    bus.rf_capture_mode_sync    = mode;
    bus.rf_96path_en_sync       = p96;
    bus.rf_pkt_data_length_sync = 2'(len);
    bus.rf_pktctrl_gap_sync     = 9'(gap);
    bus.rf_pkt_idle_length_sync = 16'(idle);
    bus.rf_pktctrl_phase_sync   = 9'(phase);
  endtask

  // Start goes low then high; t is the first cycle with start high.
  task automatic rise_start(output int t);
    bus.rf_capture_start_sync = 1'b0;
    step();
    step();
    bus.rf_capture_start_sync = 1'b1;
    t = cyc;
  endtask

  task automatic wait_words(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (obs.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      step();
      if (bus.cap_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy_low(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      step();
      if (bus.cap_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expected words of one packet: word k is emitted in cycle first+k*(gap+1),
  // appears one cycle later and carries the sample of its emit cycle.
  task automatic model_pkt(input int first, input int n, input int gap, input bit p96,
                           output int eop_emit);
    int e = first;
    int paths = p96 ? 96 : 48;
    for (int k = 0; k < n; k++) begin
      e = first + k * (gap + 1);
      exp_q.push_back({e + 1, k == 0, k == n - 1, 7'(m_path), AW'(m_addr), adc_hist[e]});
      m_path = (m_path + 1) % paths;
      m_addr = (m_addr + 1) % (1 << AW);
    end
    eop_emit = e;
  endtask

  task automatic test_reset();
    set_cfg(0, 0, 0, 0, 0, 0);
    bus.rf_capture_start_sync = 1'b0;
    bus.rf_capture_again_sync = 1'b0;
    rstn = 1'b0;
    repeat (3) step();
    n_assert++;
    if ({bus.pkt_valid, bus.pkt_sop, bus.pkt_eop} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset strobes: got %b want 000", {bus.pkt_valid, bus.pkt_sop, bus.pkt_eop});
    end
    n_assert++;
    if (bus.pkt_data !== '0) begin
      n_fail++;
      $display("FAIL reset data: got %h want 0", bus.pkt_data);
    end
    n_assert++;
    if ({bus.pkt_path, bus.cap_waddr} !== '0) begin
      n_fail++;
      $display("FAIL reset path/waddr: got %0d/%0d want 0/0", bus.pkt_path, bus.cap_waddr);
    end
    n_assert++;
    if ({bus.cap_busy, bus.cap_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset status: got busy=%b done=%b want 0/0", bus.cap_busy, bus.cap_done);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    int t, e;
    bit ok;
    bit p96 = 1'($urandom);
    set_cfg(0, p96, 0, 0, 0, 3);
    obs.delete();
    exp_q.delete();
    rise_start(t);
    wait_done(2000, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single done: got cap_done=%b want 1 within 2000 cycles", bus.cap_done);
    end
    n_assert++;
    if (bus.cap_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single busy in done: got %b want 0", bus.cap_busy);
    end
    m_addr = 0;
    m_path = 0;
    model_pkt(t + 5, 256, 0, p96, e);
    n_assert++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs.size()) begin
        n_assert++;
        if (obs[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL single word %0d: got %s want %s", i, fmt(obs[i]), fmt(exp_q[i]));
        end
      end
    end
    if (obs.size() == 256) begin
      n_assert++;
      if (obs[0].cyc != t + 6 || obs[255].waddr !== 15'd255) begin
        n_fail++;
        $display("FAIL single first/last: got cyc=%0d waddr=%0d want %0d/255",
                 obs[0].cyc, obs[255].waddr, t + 6);
      end
    end
    bus.rf_capture_start_sync = 1'b0;
    step();
    step();
    n_assert++;
    if ({bus.cap_busy, bus.cap_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL single stop: got busy=%b done=%b want 0/0", bus.cap_busy, bus.cap_done);
    end
  endtask

  task automatic test_continuous();
    int t, e;
    bit ok;
    int ph = $urandom_range(5, 0);
    set_cfg(1, 1, 0, 2, 10, ph);
    obs.delete();
    exp_q.delete();
    rise_start(t);
    wait_words(356, 5000, ok);
    bus.rf_capture_start_sync = 1'b0;
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cont words: got %0d want 356 within 5000 cycles", obs.size());
    end
    wait_busy_low(3000, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cont idle: got busy=%b want 0 within 3000 cycles", bus.cap_busy);
    end
    repeat (30) step();
    m_addr = 0;
    m_path = 0;
    model_pkt(t + 2 + ph, 256, 2, 1'b1, e);
    model_pkt(e + 10 + 2 + 1, 256, 2, 1'b1, e);
    n_assert++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL cont count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs.size()) begin
        n_assert++;
        if (obs[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL cont word %0d: got %s want %s", i, fmt(obs[i]), fmt(exp_q[i]));
        end
      end
    end
    if (obs.size() >= 257) begin
      n_assert++;
      if (obs[256].cyc - obs[255].cyc - 1 != 12 || obs[96].path !== 7'd0 ||
          obs[256].waddr !== 15'd256) begin
        n_fail++;
        $display("FAIL cont gap/wrap: got low=%0d path96=%0d waddr256=%0d want 12/0/256",
                 obs[256].cyc - obs[255].cyc - 1, obs[96].path, obs[256].waddr);
      end
    end
  endtask

  task automatic test_stop_mid();
    int t, e;
    bit ok;
    bit p96  = 1'($urandom);
    int idle = $urandom_range(20, 1);
    int ph   = $urandom_range(7, 0);
    set_cfg(1, p96, 0, 0, idle, ph);
    obs.delete();
    exp_q.delete();
    rise_start(t);
    wait_words(100, 2000, ok);
    bus.rf_capture_start_sync = 1'b0;
    wait_busy_low(2000, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stop idle: got busy=%b want 0 within 2000 cycles", bus.cap_busy);
    end
    repeat (30) step();
    m_addr = 0;
    m_path = 0;
    model_pkt(t + 2 + ph, 256, 0, p96, e);
    n_assert++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stop count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs.size()) begin
        n_assert++;
        if (obs[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL stop word %0d: got %s want %s", i, fmt(obs[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, e;
    bit ok;
    bit p96 = 1'($urandom);
    int gap = $urandom_range(3, 0);
    int ph  = $urandom_range(7, 0);
    set_cfg(1, p96, 0, gap, 0, ph);
    obs.delete();
    exp_q.delete();
    rise_start(t);
    wait_words(316, 4000, ok);
    bus.rf_capture_start_sync = 1'b0;
    wait_busy_low(4000, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b idle: got busy=%b want 0 within 4000 cycles", bus.cap_busy);
    end
    repeat (20) step();
    m_addr = 0;
    m_path = 0;
    model_pkt(t + 2 + ph, 256, gap, p96, e);
    model_pkt(e + gap + 1, 256, gap, p96, e);
    n_assert++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs.size()) begin
        n_assert++;
        if (obs[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b word %0d: got %s want %s", i, fmt(obs[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_again();
    int t, a, b, e;
    bit ok;
    bit p96 = 1'($urandom);
    int gap = $urandom_range(2, 0);
    int ph  = $urandom_range(7, 0);
    set_cfg(0, p96, 0, gap, 0, ph);
    obs.delete();
    exp_q.delete();
    rise_start(t);
    wait_done(3000, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL again done1: got cap_done=%b want 1", bus.cap_done);
    end
    repeat (3) step();
    bus.rf_capture_again_sync = 1'b1;
    a = cyc;
    step();
    bus.rf_capture_again_sync = 1'b0;
    step();
    n_assert++;
    if ({bus.cap_busy, bus.cap_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL again rearm: got busy=%b done=%b want 1/0", bus.cap_busy, bus.cap_done);
    end
    wait_done(3000, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL again done2: got cap_done=%b want 1", bus.cap_done);
    end
    repeat (2) step();
    // Re-arm and stop in the same cycle: re-arm must win.
    bus.rf_capture_again_sync = 1'b1;
    bus.rf_capture_start_sync = 1'b0;
    b = cyc;
    step();
    bus.rf_capture_again_sync = 1'b0;
    wait_done(3000, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL again done3: got cap_done=%b want 1", bus.cap_done);
    end
    repeat (2) step();
    n_assert++;
    if ({bus.cap_busy, bus.cap_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL again final: got busy=%b done=%b want 0/0", bus.cap_busy, bus.cap_done);
    end
    m_addr = 0;
    m_path = 0;
    model_pkt(t + 2 + ph, 256, gap, p96, e);
    model_pkt(a + 2 + ph, 256, gap, p96, e);
    model_pkt(b + 2 + ph, 256, gap, p96, e);
    n_assert++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL again count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs.size()) begin
        n_assert++;
        if (obs[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL again word %0d: got %s want %s", i, fmt(obs[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, e, n, n_eop;
    bit ok;
    set_cfg(0, 0, 0, 0, 0, 2);
    obs.delete();
    exp_q.delete();
    rise_start(t);
    wait_words(51, 1000, ok);
    rstn = 1'b0;
    step();
    n_assert++;
    if ({bus.pkt_valid, bus.pkt_sop, bus.pkt_eop, bus.pkt_data, bus.pkt_path, bus.cap_waddr,
         bus.cap_busy, bus.cap_done} !== '0) begin
      n_fail++;
      $display("FAIL rstmid outputs: got valid=%b data=%h path=%0d waddr=%0d busy=%b done=%b want 0",
               bus.pkt_valid, bus.pkt_data, bus.pkt_path, bus.cap_waddr, bus.cap_busy,
               bus.cap_done);
    end
    rstn = 1'b1;
    n_eop = 0;
    foreach (obs[i]) if (obs[i].eop) n_eop++;
    n_assert++;
    if (n_eop != 0) begin
      n_fail++;
      $display("FAIL rstmid eop: got %0d eop words want 0", n_eop);
    end
    n = obs.size();
    repeat (40) step();
    n_assert++;
    if (obs.size() != n || bus.cap_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid held start: got %0d new words busy=%b want 0/0",
               obs.size() - n, bus.cap_busy);
    end
    obs.delete();
    rise_start(t);
    wait_done(1000, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid restart: got cap_done=%b want 1", bus.cap_done);
    end
    m_addr = 0;
    m_path = 0;
    model_pkt(t + 4, 256, 0, 1'b0, e);
    n_assert++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs.size()) begin
        n_assert++;
        if (obs[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rstmid word %0d: got %s want %s", i, fmt(obs[i]), fmt(exp_q[i]));
        end
      end
    end
    bus.rf_capture_start_sync = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_len_change();
    int t, e;
    bit ok;
    int idle = $urandom_range(8, 1);
    set_cfg(1, 0, 0, 0, idle, 1);
    obs.delete();
    exp_q.delete();
    rise_start(t);
    wait_words(128, 1000, ok);
    bus.rf_pkt_data_length_sync = 2'd3;
    wait_words(556, 2000, ok);
    bus.rf_capture_start_sync = 1'b0;
    wait_busy_low(5000, ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL len idle: got busy=%b want 0 within 5000 cycles", bus.cap_busy);
    end
    repeat (20) step();
    m_addr = 0;
    m_path = 0;
    model_pkt(t + 3, 256, 0, 1'b0, e);
    model_pkt(e + idle + 1, 2048, 0, 1'b0, e);
    n_assert++;
    if (obs.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL len count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs.size()) begin
        n_assert++;
        if (obs[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL len word %0d: got %s want %s", i, fmt(obs[i]), fmt(exp_q[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_stop_mid();
    test_back_to_back();
    test_again();
    test_reset_mid();
    test_len_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
